// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_MIRE = 2'd1,
    GNT_VGA  = 2'd2
  } arb_state_t;

  localparam logic M_MIRE = 1'b0;
  localparam logic M_VGA  = 1'b1;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic bus bundle with master and slave views.
interface wshb_if #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 32
) (
  input logic clk
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [DATA_W/8-1:0]   sel;
  logic [ADR_W-1:0]      adr;
  logic [DATA_W-1:0]     dat_ms;
  logic [DATA_W-1:0]     dat_sm;
  logic                  ack;
  logic                  err;
  logic [2:0]            cti;
  logic [1:0]            bte;

  modport master (
    output cyc, stb, we, sel, adr, dat_ms, cti, bte,
    input  dat_sm, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
    output dat_sm, ack, err
  );

endinterface

// File: rtl/wshb_arb_fsm.sv
// Round-robin grant FSM with a per-grant acknowledge budget.
module wshb_arb_fsm
  import wshb_arb_pkg::*;
#(
  parameter int MAX_ACKS = 64,
  parameter int CNT_W    = $clog2(MAX_ACKS + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cyc_mire,
  input  logic       cyc_vga,
  input  logic       ack,
  output arb_state_t state,
  output logic       force_idle
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ACKS);

  arb_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic             other_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= M_VGA;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    ack_cnt_d = ack_cnt_q;
    case (state_q)
      IDLE: begin
        ack_cnt_d = '0;
        // On a tie the master that was not served last wins.
        if (cyc_mire && (!cyc_vga || last_q == M_VGA)) begin
          state_d = GNT_MIRE;
          last_d  = M_MIRE;
        end else if (cyc_vga) begin
          state_d = GNT_VGA;
          last_d  = M_VGA;
        end
      end
      GNT_MIRE, GNT_VGA: begin
        if (ack && !force_idle && ack_cnt_q != MAX_CNT)
          ack_cnt_d = ack_cnt_q + 1'b1;
        if (force_idle || (state_q == GNT_MIRE ? !cyc_mire : !cyc_vga))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    other_req = 1'b0;
    case (state_q)
      GNT_MIRE: other_req = cyc_vga;
      GNT_VGA:  other_req = cyc_mire;
      default:  other_req = 1'b0;
    endcase
    force_idle = other_req && (ack_cnt_q == MAX_CNT);
    state      = state_q;
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter: mire and vga share the SDRAM slave port.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_ACKS = 64,
  parameter int CNT_W    = $clog2(MAX_ACKS + 1)
) (
  input  logic   clk,
  input  logic   rst,
  wshb_if.slave  wshb_ifs_mire,
  wshb_if.slave  wshb_ifs_vga,
  wshb_if.master wshb_ifm_sdram
);

  arb_state_t state;
  logic       force_idle;

  wshb_arb_fsm #(
    .MAX_ACKS (MAX_ACKS),
    .CNT_W    (CNT_W)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .cyc_mire   (wshb_ifs_mire.cyc),
    .cyc_vga    (wshb_ifs_vga.cyc),
    .ack        (wshb_ifm_sdram.ack),
    .state      (state),
    .force_idle (force_idle)
  );

  assign wshb_ifs_mire.dat_sm = wshb_ifm_sdram.dat_sm;
  assign wshb_ifs_vga.dat_sm  = wshb_ifm_sdram.dat_sm;

  // A forced release only gates cyc/stb and the replies; the rest stays routed.
  always_comb begin
    wshb_ifm_sdram.cyc    = 1'b0;
    wshb_ifm_sdram.stb    = 1'b0;
    wshb_ifm_sdram.we     = 1'b0;
    wshb_ifm_sdram.sel    = '0;
    wshb_ifm_sdram.adr    = '0;
    wshb_ifm_sdram.dat_ms = '0;
    wshb_ifm_sdram.cti    = '0;
    wshb_ifm_sdram.bte    = '0;
    wshb_ifs_mire.ack     = 1'b0;
    wshb_ifs_mire.err     = 1'b0;
    wshb_ifs_vga.ack      = 1'b0;
    wshb_ifs_vga.err      = 1'b0;
    case (state)
      GNT_MIRE: begin
        wshb_ifm_sdram.cyc    = wshb_ifs_mire.cyc & ~force_idle;
        wshb_ifm_sdram.stb    = wshb_ifs_mire.stb & ~force_idle;
        wshb_ifm_sdram.we     = wshb_ifs_mire.we;
        wshb_ifm_sdram.sel    = wshb_ifs_mire.sel;
        wshb_ifm_sdram.adr    = wshb_ifs_mire.adr;
        wshb_ifm_sdram.dat_ms = wshb_ifs_mire.dat_ms;
        wshb_ifm_sdram.cti    = wshb_ifs_mire.cti;
        wshb_ifm_sdram.bte    = wshb_ifs_mire.bte;
        wshb_ifs_mire.ack     = wshb_ifm_sdram.ack & ~force_idle;
        wshb_ifs_mire.err     = wshb_ifm_sdram.err & ~force_idle;
      end
      GNT_VGA: begin
        wshb_ifm_sdram.cyc    = wshb_ifs_vga.cyc & ~force_idle;
        wshb_ifm_sdram.stb    = wshb_ifs_vga.stb & ~force_idle;
        wshb_ifm_sdram.we     = wshb_ifs_vga.we;
        wshb_ifm_sdram.sel    = wshb_ifs_vga.sel;
        wshb_ifm_sdram.adr    = wshb_ifs_vga.adr;
        wshb_ifm_sdram.dat_ms = wshb_ifs_vga.dat_ms;
        wshb_ifm_sdram.cti    = wshb_ifs_vga.cti;
        wshb_ifm_sdram.bte    = wshb_ifs_vga.bte;
        wshb_ifs_vga.ack      = wshb_ifm_sdram.ack & ~force_idle;
        wshb_ifs_vga.err      = wshb_ifm_sdram.err & ~force_idle;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Randomized and directed bench for wshb_arbiter against a grant-level reference model.
module tb_wshb_arbiter;

  localparam int MAX_ACKS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wshb_if mire_if  (clk);
  wshb_if vga_if   (clk);
  wshb_if sdram_if (clk);

  wshb_arbiter #(.MAX_ACKS(MAX_ACKS)) dut (
    .clk            (clk),
    .rst            (rst),
    .wshb_ifs_mire  (mire_if),
    .wshb_ifs_vga   (vga_if),
    .wshb_ifm_sdram (sdram_if)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  // Reference model: who owns the bus (0 none, 1 mire, 2 vga), acks served in this grant, last owner.
  int owner;
  int served;
  int last_owner;

  // Per-cycle record of which master received an ack (0 none, 1 mire, 2 vga).
  int trace[$];
  int run_kind[$];
  int run_len[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner      = 0;
    served     = 0;
    last_owner = 2;
    trace.delete();
  endtask

  task automatic driveMasters(input bit mc, input bit vc, input logic [31:0] madr, input logic [31:0] vadr);
    mire_if.cyc    = mc;
    mire_if.stb    = mc;
    mire_if.we     = 1'b1;
    mire_if.sel    = 4'hF;
    mire_if.adr    = madr;
    mire_if.dat_ms = ~madr;
    mire_if.cti    = 3'd0;
    mire_if.bte    = 2'd0;
    vga_if.cyc     = vc;
    vga_if.stb     = vc;
    vga_if.we      = 1'b0;
    vga_if.sel     = 4'h3;
    vga_if.adr     = vadr;
    vga_if.dat_ms  = vadr ^ 32'h5A5A_A5A5;
    vga_if.cti     = 3'd2;
    vga_if.bte     = 2'd1;
  endtask

  // One bus cycle: drive at the falling edge, check just after, then let the rising edge pass.
  task automatic applyStimulus(input bit mc, input bit vc, input bit sack, input bit serr);
    logic [31:0] madr, vadr, sdat, e_adr, e_dat;
    bit          own_req, other_req, preempt, e_we;
    logic [3:0]  e_sel;
    madr = $urandom;
    vadr = $urandom;
    sdat = $urandom;
    driveMasters(mc, vc, madr, vadr);
    sdram_if.ack    = sack;
    sdram_if.err    = serr;
    sdram_if.dat_sm = sdat;
    #1;
    own_req   = (owner == 1) ? mc : (owner == 2) ? vc : 1'b0;
    other_req = (owner == 1) ? vc : (owner == 2) ? mc : 1'b0;
    preempt   = (owner != 0) && (served >= MAX_ACKS) && other_req;
    e_adr     = (owner == 1) ? madr : (owner == 2) ? vadr : 32'd0;
    e_dat     = (owner == 1) ? ~madr : (owner == 2) ? (vadr ^ 32'h5A5A_A5A5) : 32'd0;
    e_we      = (owner == 1);
    e_sel     = (owner == 1) ? 4'hF : (owner == 2) ? 4'h3 : 4'h0;
    checkOutput("s_cyc",    32'(sdram_if.cyc),    32'(own_req && !preempt));
    checkOutput("s_stb",    32'(sdram_if.stb),    32'(own_req && !preempt));
    checkOutput("s_adr",    sdram_if.adr,         e_adr);
    checkOutput("s_dat_ms", sdram_if.dat_ms,      e_dat);
    checkOutput("s_we",     32'(sdram_if.we),     32'(e_we));
    checkOutput("s_sel",    32'(sdram_if.sel),    32'(e_sel));
    checkOutput("mire_ack", 32'(mire_if.ack),     32'(owner == 1 && sack && !preempt));
    checkOutput("vga_ack",  32'(vga_if.ack),      32'(owner == 2 && sack && !preempt));
    checkOutput("mire_err", 32'(mire_if.err),     32'(owner == 1 && serr && !preempt));
    checkOutput("vga_err",  32'(vga_if.err),      32'(owner == 2 && serr && !preempt));
    checkOutput("mire_dat", mire_if.dat_sm,       sdat);
    checkOutput("vga_dat",  vga_if.dat_sm,        sdat);
    trace.push_back(mire_if.ack ? 1 : (vga_if.ack ? 2 : 0));
    if (owner == 0) begin
      served = 0;
      if (mc && (!vc || last_owner == 2)) begin
        owner = 1; last_owner = 1;
      end else if (vc) begin
        owner = 2; last_owner = 2;
      end
    end else if (!own_req || preempt) begin
      owner = 0;
    end else if (sack && served < MAX_ACKS) begin
      served++;
    end
    @(negedge clk);
  endtask

  task automatic doReset(input bit mc, input bit vc);
    rst = 1'b1;
    driveMasters(mc, vc, 32'h1111_0000, 32'h2222_0000);
    sdram_if.ack    = 1'b1;
    sdram_if.err    = 1'b0;
    sdram_if.dat_sm = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_s_cyc",    32'(sdram_if.cyc), 32'd0);
    checkOutput("rst_mire_ack", 32'(mire_if.ack),  32'd0);
    checkOutput("rst_vga_ack",  32'(vga_if.ack),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic computeRuns();
    run_kind.delete();
    run_len.delete();
    foreach (trace[i]) begin
      if (run_kind.size() != 0 && run_kind[$] == trace[i])
        run_len[run_len.size()-1]++;
      else begin
        run_kind.push_back(trace[i]);
        run_len.push_back(1);
      end
    end
  endtask

  initial begin
    bit mc, vc;
    driveMasters(1'b0, 1'b0, 32'h0, 32'h0);
    sdram_if.ack    = 1'b0;
    sdram_if.err    = 1'b0;
    sdram_if.dat_sm = 32'h0;
    modelReset();
    @(negedge clk);

    // Reset with both requesting; mire wins the first tie.
    doReset(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("first_grant_mire", 32'(trace[1]), 32'd1);

    // Single master: the budget saturates without releasing the grant.
    doReset(1'b0, 1'b1);
    repeat (301) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    computeRuns();
    checkOutput("single_runs",    32'(run_kind.size()), 32'd2);
    checkOutput("single_streak",  32'(run_len[run_len.size()-1]), 32'd300);

    // Contention: 64 acks each, two dead cycles between grants.
    doReset(1'b1, 1'b1);
    repeat (300) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    computeRuns();
    checkOutput("cont_kind1", 32'(run_kind[1]), 32'd1);
    checkOutput("cont_len1",  32'(run_len[1]),  32'd64);
    checkOutput("cont_gap2",  32'(run_len[2]),  32'd2);
    checkOutput("cont_kind3", 32'(run_kind[3]), 32'd2);
    checkOutput("cont_len3",  32'(run_len[3]),  32'd64);
    checkOutput("cont_gap4",  32'(run_len[4]),  32'd2);
    checkOutput("cont_kind5", 32'(run_kind[5]), 32'd1);
    checkOutput("cont_len5",  32'(run_len[5]),  32'd64);

    // Voluntary release by mire after 10 acks while vga waits.
    doReset(1'b1, 1'b1);
    repeat (11) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    computeRuns();
    checkOutput("vol_mire_acks", 32'(run_len[1]),  32'd10);
    checkOutput("vol_gap",       32'(run_len[2]),  32'd2);
    checkOutput("vol_vga_kind",  32'(run_kind[3]), 32'd2);

    // Tie from IDLE after vga was last served.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("tie_winner", 32'(trace[trace.size()-1]), 32'd1);

    // Reset pulse in the middle of a vga transfer.
    doReset(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    driveMasters(1'b0, 1'b1, 32'h3333_0000, 32'h4444_0000);
    sdram_if.ack = 1'b0;
    #1;
    checkOutput("mid_pre_cyc", 32'(sdram_if.cyc), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_cyc", 32'(sdram_if.cyc), 32'd0);
    sdram_if.ack = 1'b1;
    #1;
    checkOutput("mid_rst_ack", 32'(vga_if.ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic with long-held requests so budgets run out.
    doReset(1'b0, 1'b0);
    mc = 1'b0;
    vc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) mc = ~mc;
      if ($urandom_range(0, 99) < 3) vc = ~vc;
      applyStimulus(mc, vc, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
